mem_access_stage: RTL

Pipeline MEM stage of the RV32 core, between the EX/MEM pipeline register and the MEM/WB pipeline register. It runs loads and stores against a data-memory bus with a request/grant/response handshake. It builds byte enables and store-data lane placement, then sign- or zero-extends load data. It holds the pipeline via `stall_o` while an access is outstanding and hands the load result and pass-through control fields to MEM/WB.

---
 rtl/mem_pkg.sv | 51 +++++
 rtl/dmem_if.sv | 31 +++
 rtl/load_align.sv | 34 +++
 rtl/mem_access_stage.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared definitions for the MEM stage: funct3 codes, FSM state
//               type and bus lane helpers (byte enables, store data, misalign).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // funct3[1:0]: 00 byte, 01 half, anything else is a full word
    function automatic logic [3:0] gen_be(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   gen_be = 4'b0001 << addr_lo;
            2'b01:   gen_be = 4'b0011 << {addr_lo[1], 1'b0};
            default: gen_be = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] gen_wdata(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3[1:0])
            2'b00:   gen_wdata = {4{data[7:0]}};
            2'b01:   gen_wdata = {2{data[15:0]}};
            default: gen_wdata = data;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = addr_lo[0];
            default: is_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_if.sv
// ============================================================================
// Module      : dmem_if
// Description : Data-memory bus with request/grant/response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_if #(
    parameter int DW = 32
);
    logic            req;
    logic            we;
    logic [DW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] be;
    logic            gnt;
    logic            rvalid;
    logic [DW-1:0]   rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module      : load_align
// Description : Selects the addressed byte/halfword lane of a read word and
//               sign- or zero-extends it to 32 bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        // halfword lane ignores addr[0]
        half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  result_o = {24'd0, byte_sel};
            F3_LHU:  result_o = {16'd0, half_sel};
            default: result_o = rdata_i;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module      : mem_access_stage
// Description : RV32 MEM pipeline stage; runs loads/stores over dmem_if and
//               stalls the pipeline while an access is outstanding.
//               Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int REGINDEX  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] alu_result_i,
    input  logic [DATAWIDTH-1:0] store_data_i,
    input  logic [2:0]           funct3_i,
    input  logic                 mem_read_i,
    input  logic                 mem_write_i,
    input  logic [REGINDEX-1:0]  rd_i,
    input  logic [1:0]           wbsel_i,
    input  logic                 regwrite_i,
    input  logic [31:0]          pc_i,
    output logic [DATAWIDTH-1:0] data_mem_o,
    output logic [DATAWIDTH-1:0] data_alu_o,
    output logic [REGINDEX-1:0]  rd_o,
    output logic [1:0]           wbsel_o,
    output logic [31:0]          pc_o,
    output logic                 regwrite_o,
    output logic                 stall_o,
    output logic                 misalign_o,
    dmem_if.master               dmem
);
    state_e               state_q,   state_d;
    logic [DATAWIDTH-3:0] waddr_q,   waddr_d;
    logic                 we_q,      we_d;
    logic [3:0]           be_q,      be_d;
    logic [31:0]          wdata_q,   wdata_d;
    logic [31:0]          rdata_q,   rdata_d;
    logic [2:0]           funct3_q,  funct3_d;
    logic [1:0]           addr_lo_q, addr_lo_d;

    logic        mem_op;
    logic        misaligned;
    logic        start;
    logic [31:0] load_fmt;

    load_align u_load_align (
        .rdata_i   (dmem.rdata),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .result_o  (load_fmt)
    );

    always_comb begin
        mem_op = mem_read_i | mem_write_i;
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = is_misaligned(funct3_i, alu_result_i[1:0]);
`else
        misaligned = 1'b0;
`endif
        start      = (state_q == ST_IDLE) && mem_op && !misaligned;
        misalign_o = (state_q == ST_IDLE) && mem_op && misaligned;
        stall_o    = start || (state_q == ST_REQ) || (state_q == ST_RESP);
        regwrite_o = regwrite_i && !misalign_o;

        state_d   = state_q;
        waddr_d   = waddr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;

        case (state_q)
            ST_IDLE: begin
                // Capture the request so the bus stays stable while waiting for gnt
                if (start) begin
                    state_d   = ST_REQ;
                    waddr_d   = alu_result_i[DATAWIDTH-1:2];
                    we_d      = mem_write_i;
                    be_d      = gen_be(funct3_i, alu_result_i[1:0]);
                    wdata_d   = gen_wdata(funct3_i, store_data_i);
                    funct3_d  = funct3_i;
                    addr_lo_d = alu_result_i[1:0];
                end
            end
            ST_REQ: begin
                if (dmem.gnt) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (dmem.rvalid) begin
                    if (!we_q) rdata_d = load_fmt;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            waddr_q   <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
        end
    end

    assign dmem.req   = (state_q == ST_REQ);
    assign dmem.we    = we_q;
    assign dmem.addr  = {waddr_q, 2'b00};
    assign dmem.be    = be_q;
    assign dmem.wdata = wdata_q;

    assign data_mem_o = rdata_q;
    assign data_alu_o = alu_result_i;
    assign rd_o       = rd_i;
    assign wbsel_o    = wbsel_i;
    assign pc_o       = pc_i;

endmodule

`default_nettype wire
